// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding split addr/data request, registered id_* output plus a one-entry skid.
// id_* valid the cycle after data_ok; stall_o/inst_req combinational; decode backpressure parks a response in the skid.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        pc_alignment_error_i,
    output logic        stall_o,
    input  logic        flush_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_adel_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state;
    logic [31:0] req_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        can_load;
    logic        err_load;
    logic        rsp_load;
    logic        skid_load;
    logic        any_load;

    assign can_load  = !id_valid_o || id_ready_i;
    assign inst_req  = (state == S_REQ) && !pc_alignment_error_i;
    assign inst_addr = pc_i;
    assign err_load  = (state == S_REQ) && pc_alignment_error_i && can_load;
    assign rsp_load  = (state == S_WAIT) && inst_data_ok && can_load;
    assign skid_load = (state == S_HOLD) && id_ready_i;
    // A flush suppresses every load, so the PC holds the redirect target.
    assign any_load  = !flush_i && (err_load || rsp_load || skid_load);
    assign stall_o   = !any_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            req_pc     <= RESET_PC;
            skid_pc    <= '0;
            skid_inst  <= '0;
            id_valid_o <= 1'b0;
            id_pc_o    <= RESET_PC;
            id_inst_o  <= '0;
            id_adel_o  <= 1'b0;
        end else begin
            if (state == S_REQ) begin
                req_pc <= pc_i;
            end

            case (state)
                S_REQ: begin
                    if (inst_req && inst_addr_ok) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state <= (flush_i || can_load) ? S_REQ : S_HOLD;
                    end else if (flush_i) begin
                        state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (flush_i || id_ready_i) begin
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (inst_data_ok) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            // Skid contents are only meaningful while in S_HOLD.
            if ((state == S_WAIT) && inst_data_ok && !can_load && !flush_i) begin
                skid_pc   <= req_pc;
                skid_inst <= inst_rdata;
            end

            if (flush_i) begin
                id_valid_o <= 1'b0;
            end else if (any_load) begin
                id_valid_o <= 1'b1;
                id_pc_o    <= err_load ? pc_i : (skid_load ? skid_pc : req_pc);
                id_inst_o  <= err_load ? NOP_INST : (skid_load ? skid_inst : inst_rdata);
                id_adel_o  <= err_load;
            end else if (id_valid_o && id_ready_i) begin
                id_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: closed-loop PC and memory models with a transaction-level model of the
// output register + skid as a two-entry in-order queue.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_i = RST_PC;
    logic        pc_alignment_error_i;
    logic        stall_o;
    logic        flush_i = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b1;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_adel_o;

    assign pc_alignment_error_i = |pc_i[1:0];

    inst_fetch dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pc_i                 (pc_i),
        .pc_alignment_error_i (pc_alignment_error_i),
        .stall_o              (stall_o),
        .flush_i              (flush_i),
        .inst_req             (inst_req),
        .inst_addr            (inst_addr),
        .inst_addr_ok         (inst_addr_ok),
        .inst_data_ok         (inst_data_ok),
        .inst_rdata           (inst_rdata),
        .id_valid_o           (id_valid_o),
        .id_ready_i           (id_ready_i),
        .id_pc_o              (id_pc_o),
        .id_inst_o            (id_inst_o),
        .id_adel_o            (id_adel_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } ent_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          delivered = 0;
    ent_t        pend[$];
    bit          mem_busy = 1'b0;
    bit          mem_drop = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_lat = 0;
    bit          last_stall = 1'b1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hbfc0_0000) return 32'h2408_0001;
        return {a[15:0] ^ 16'h5a5a, a[31:16] + 16'h1234};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, then check and advance the model at the falling edge.
    task automatic cycle(input bit fl, input logic [31:0] tgt, input bit rdy, input bit aok, input int lat);
        bit   pops;
        bit   push;
        bit   ld;
        bit   exp_req;
        int   post;
        ent_t e;
        @(posedge clk);
        #1;
        if (fl) pc_i = tgt;
        else if (!last_stall) pc_i = pc_i + 32'd4;
        flush_i      = fl;
        id_ready_i   = rdy;
        inst_data_ok = mem_busy && (mem_lat == 0);
        if (mem_busy && mem_lat > 0) mem_lat--;
        inst_rdata   = inst_data_ok ? mem_word(mem_addr) : 32'hdead_beef;
        inst_addr_ok = 1'b0;
        #1;
        inst_addr_ok = inst_req && !mem_busy && aok;
        @(negedge clk);

        exp_req = !mem_busy && (pend.size() < 2) && !pc_alignment_error_i;
        pops    = rdy && (pend.size() > 0);
        post    = pend.size() - int'(pops);
        push    = 1'b0;
        ld      = 1'b0;
        e       = '{32'h0, 32'h0, 1'b0};
        if (!fl) begin
            if (inst_data_ok && !mem_drop) begin
                push = 1'b1;
                e    = '{mem_addr, mem_word(mem_addr), 1'b0};
            end else if (!mem_busy && pend.size() < 2 && pc_alignment_error_i && post == 0) begin
                push = 1'b1;
                e    = '{pc_i, 32'h0, 1'b1};
            end
            ld = (push && post == 0) || (pops && pend.size() == 2);
        end

        chk("id_valid", 32'(id_valid_o), 32'(pend.size() > 0));
        if (pend.size() > 0) begin
            chk("id_pc", id_pc_o, pend[0].pc);
            chk("id_inst", id_inst_o, pend[0].inst);
            chk("id_adel", 32'(id_adel_o), 32'(pend[0].adel));
        end
        chk("inst_addr", inst_addr, pc_i);
        chk("inst_req", 32'(inst_req), 32'(exp_req));
        chk("stall", 32'(stall_o), 32'(!ld));

        if (fl) begin
            pend.delete();
        end else begin
            if (pops) begin
                void'(pend.pop_front());
                delivered++;
            end
            if (push) pend.push_back(e);
        end
        if (inst_data_ok) begin
            mem_busy = 1'b0;
            mem_drop = 1'b0;
        end else if (fl && mem_busy) begin
            mem_drop = 1'b1;
        end
        if (inst_addr_ok) begin
            mem_busy = 1'b1;
            mem_drop = 1'b0;
            mem_addr = inst_addr;
            mem_lat  = lat;
        end
        last_stall = stall_o;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(id_valid_o), 32'h0);
        chk({tag, "_pc"}, id_pc_o, RST_PC);
        chk({tag, "_inst"}, id_inst_o, 32'h0);
        chk({tag, "_adel"}, 32'(id_adel_o), 32'h0);
    endtask

    initial begin
        bit          fl;
        logic [31:0] tgt;

        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset release, zero-wait memory.
        cycle(0, 0, 1, 1, 0);  chk("first_req", 32'(inst_req), 32'h1);
        cycle(0, 0, 1, 1, 0);  chk("rsp_stall", 32'(stall_o), 32'h0);
        cycle(0, 0, 0, 1, 0);
        chk("first_valid", 32'(id_valid_o), 32'h1);
        chk("first_pc", id_pc_o, 32'hbfc0_0000);
        chk("first_inst", id_inst_o, 32'h2408_0001);
        // Decode backpressure: second response parks in the skid.
        cycle(0, 0, 0, 1, 0);  chk("skid_stall", 32'(stall_o), 32'h1);
        cycle(0, 0, 0, 1, 0);  chk("hold_req", 32'(inst_req), 32'h0);
        chk("hold_pc", id_pc_o, 32'hbfc0_0000);
        cycle(0, 0, 1, 1, 0);  chk("skid_xfer_stall", 32'(stall_o), 32'h0);
        cycle(0, 0, 1, 1, 3);
        chk("second_pc", id_pc_o, 32'hbfc0_0004);
        chk("second_inst", id_inst_o, 32'h5a5e_d1f4);
        // Flush while waiting; stale data arrives three cycles later.
        cycle(1, 32'hbfc0_0100, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);  chk("drop_req", 32'(inst_req), 32'h0);
        cycle(0, 0, 1, 1, 0);  chk("drop_valid", 32'(id_valid_o), 32'h0);
        cycle(0, 0, 1, 1, 0);  chk("stale_stall", 32'(stall_o), 32'h1);
        cycle(0, 0, 1, 1, 0);
        chk("tgt_req", 32'(inst_req), 32'h1);
        chk("tgt_addr", inst_addr, 32'hbfc0_0100);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);  chk("tgt_pc", id_pc_o, 32'hbfc0_0100);
        // Misaligned target.
        cycle(1, 32'hbfc0_0102, 1, 0, 0);  chk("mis_req", 32'(inst_req), 32'h0);
        cycle(0, 0, 1, 0, 0);  chk("mis_stall", 32'(stall_o), 32'h0);
        cycle(1, 32'hbfc0_0200, 1, 1, 0);
        chk("adel_valid", 32'(id_valid_o), 32'h1);
        chk("adel_flag", 32'(id_adel_o), 32'h1);
        chk("adel_inst", id_inst_o, 32'h0);
        chk("adel_pc", id_pc_o, 32'hbfc0_0102);
        // Flush in the same cycle as data_ok.
        cycle(1, 32'hbfc0_0300, 1, 1, 0);  chk("flush_rsp_stall", 32'(stall_o), 32'h1);
        cycle(0, 0, 1, 1, 2);
        chk("flush_rsp_valid", 32'(id_valid_o), 32'h0);
        chk("flush_rsp_req", 32'(inst_req), 32'h1);
        chk("flush_rsp_addr", inst_addr, 32'hbfc0_0300);
        cycle(0, 0, 1, 1, 0);

        // Asynchronous reset pulse while a request is outstanding.
        #2;
        rst_n = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        flush_i = 1'b0;
        pc_i = RST_PC;
        #1;
        chk_reset_vals("async_rst");
        pend.delete();
        mem_busy = 1'b0;
        mem_drop = 1'b0;
        last_stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1, 1, 1);
        chk("restart_req", 32'(inst_req), 32'h1);
        chk("restart_addr", inst_addr, RST_PC);

        // Randomized traffic.
        delivered = 0;
        for (int i = 0; i < 4000; i++) begin
            fl  = ($urandom % 16) == 0;
            tgt = 32'hbfc0_0000 + ($urandom % 1024) * 4 + ((($urandom % 4) == 0) ? 32'd2 : 32'd0);
            cycle(fl, tgt, ($urandom % 4) != 0, ($urandom % 3) != 0, int'($urandom % 4));
        end
        chk("progress", 32'(delivered > 300), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
